muldiv_unit: RTL and testbench

- Iterative multiply/divide unit hanging off the EXE stage of pipeline_cpu; owns the HI/LO registers exported as HI_data/LO_data.
- Accepts one operation per start pulse from EXE and runs it over multiple cycles. EXE stalls on busy and retires the instruction on done.
- Also services MTHI/MTLO single-cycle writes.

---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with single-cycle MTHI/MTLO writes.
// Optional MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            resten,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            cancel,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi_data,
   output logic [XLEN-1:0] lo_data
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [2*XLEN-1:0]   acc;
   logic [2*XLEN-1:0]   mcand;
   logic [XLEN-1:0]     mplier;
   logic                is_div, res_neg, rem_neg, div_zero;

   logic                signed_op;
   logic [XLEN-1:0]     mag1, mag2;
   logic [2*XLEN-1:0]   mul_sum;
   logic                mul_last, last_iter;
   logic [XLEN:0]       shifted;
   logic                ge;
   logic [XLEN-1:0]     rem_sub;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix;

   always_comb begin
      signed_op = (op == 3'd0) || (op == 3'd2);
      mag1      = (signed_op && src1[XLEN-1]) ? -src1 : src1;
      mag2      = (signed_op && src2[XLEN-1]) ? -src2 : src2;
      last_iter = (cnt == CNT_W'(XLEN-1));
      mul_sum   = acc + (mplier[0] ? mcand : '0);
`ifdef MULDIV_EARLY_OUT_EN
      mul_last  = last_iter || (mplier[XLEN-1:1] == '0);
`else
      mul_last  = last_iter;
`endif
      // Restoring step: remainder lives in acc's upper half, dividend shifts out of the lower half
      shifted   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      ge        = (shifted >= {1'b0, mcand[XLEN-1:0]});
      rem_sub   = shifted[XLEN-1:0] - mcand[XLEN-1:0];
      prod_fix  = res_neg ? -acc : acc;
      quo_fix   = res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_fix   = rem_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk) begin
      if (resten) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi_data  <= '0;
         lo_data  <= '0;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         is_div   <= 1'b0;
         res_neg  <= 1'b0;
         rem_neg  <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !cancel) begin
                  case (op)
                     3'd0, 3'd1: begin
                        state   <= MUL;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        is_div  <= 1'b0;
                        acc     <= '0;
                        mcand   <= {{XLEN{1'b0}}, mag1};
                        mplier  <= mag2;
                        res_neg <= (op == 3'd0) && (src1[XLEN-1] ^ src2[XLEN-1]);
                     end
                     3'd2, 3'd3: begin
                        state    <= DIV;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        is_div   <= 1'b1;
                        acc      <= {{XLEN{1'b0}}, mag1};
                        mcand    <= {{XLEN{1'b0}}, mag2};
                        res_neg  <= (op == 3'd2) && (src1[XLEN-1] ^ src2[XLEN-1]);
                        rem_neg  <= (op == 3'd2) && src1[XLEN-1];
                        div_zero <= (src2 == '0);
                     end
                     3'd4:    hi_data <= src1;
                     3'd5:    lo_data <= src1;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               if (cancel) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc    <= mul_sum;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
                  if (mul_last) state <= FIX;
               end
            end
            DIV: begin
               if (cancel) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc <= ge ? {rem_sub, acc[XLEN-2:0], 1'b1}
                            : {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                  cnt <= cnt + 1'b1;
                  if (last_iter) state <= FIX;
               end
            end
            FIX: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (!cancel) begin
                  done <= 1'b1;
                  if (!is_div) begin
                     hi_data <= prod_fix[2*XLEN-1:XLEN];
                     lo_data <= prod_fix[XLEN-1:0];
                  end else if (!div_zero) begin
                     lo_data <= quo_fix;
                     hi_data <= rem_fix;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases followed by random operations.
module tb_muldiv_unit;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            resten, start, cancel;
   logic [2:0]      op;
   logic [XLEN-1:0] src1, src2;
   logic            busy, done;
   logic [XLEN-1:0] hi_data, lo_data;

   typedef struct {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
      int              cyc;
   } exp_t;

   exp_t            sb[$];
   exp_t            mon_e;
   int              checks = 0;
   int              failures = 0;
   int              cyc = 0;
   logic [XLEN-1:0] m_hi = '0, m_lo = '0;

   muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk(clk), .resten(resten), .start(start), .op(op), .src1(src1), .src2(src2),
      .cancel(cancel), .busy(busy), .done(done), .hi_data(hi_data), .lo_data(lo_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain arithmetic on 64-bit values, latency from the iteration count rules
   task automatic model(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output bit multi, output logic [XLEN-1:0] nhi, output logic [XLEN-1:0] nlo,
                        output int lat);
      longint          sa, sbv;
      logic [63:0]     p, q, r;
      logic [XLEN-1:0] mb;
      int              n;
      sa    = longint'($signed(a));
      sbv   = longint'($signed(b));
      nhi   = m_hi;
      nlo   = m_lo;
      multi = (o <= 3'd3);
      lat   = XLEN + 1;
      case (o)
         3'd0: begin p = sa * sbv; nhi = p[63:32]; nlo = p[31:0]; end
         3'd1: begin p = {32'b0, a} * {32'b0, b}; nhi = p[63:32]; nlo = p[31:0]; end
         3'd2: if (b != 0) begin q = sa / sbv; r = sa % sbv; nlo = q[31:0]; nhi = r[31:0]; end
         3'd3: if (b != 0) begin nlo = a / b; nhi = a % b; end
         3'd4: nhi = a;
         3'd5: nlo = a;
         default: ;
      endcase
`ifdef MULDIV_EARLY_OUT_EN
      if (o <= 3'd1) begin
         mb = (o == 3'd0 && b[31]) ? -b : b;
         n = 1;
         for (int i = 0; i < XLEN; i++) if (mb[i]) n = i + 1;
         lat = n + 1;
      end
`else
      mb = '0;
      n  = 0;
`endif
   endtask

   // Called at a falling edge; returns at the falling edge right after the sampling edge.
   task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input bit expect_done);
      bit              multi;
      logic [XLEN-1:0] nhi, nlo;
      int              lat;
      exp_t            e;
      op = o; src1 = a; src2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model(o, a, b, multi, nhi, nlo, lat);
      if (multi) begin
         if (expect_done) begin
            e.hi = nhi; e.lo = nlo; e.cyc = cyc + lat;
            sb.push_back(e);
            m_hi = nhi; m_lo = nlo;
         end
      end else begin
         m_hi = nhi; m_lo = nlo;
         chk("imm_hi", hi_data, m_hi);
         chk("imm_lo", lo_data, m_lo);
         chk("imm_busy", {31'b0, busy}, 32'd0);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("done_hi", hi_data, mon_e.hi);
            chk("done_lo", lo_data, mon_e.lo);
            chk("done_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      resten = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; src1 = '0; src2 = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_hi", hi_data, 32'd0);
      chk("rst_lo", lo_data, 32'd0);
      resten = 1'b0;
      @(negedge clk);

      issue(3'd4, 32'h12345678, 32'h0, 1);
      issue(3'd5, 32'h9ABCDEF0, 32'h0, 1);
      issue(3'd0, 32'h80000000, 32'h80000000, 1); wait_idle();
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1); wait_idle();
      issue(3'd1, 32'd5, 32'd3, 1);               wait_idle();
      issue(3'd2, 32'hFFFFFFF9, 32'd2, 1);        wait_idle();
      issue(3'd4, 32'hAA, 32'h0, 1);
      issue(3'd5, 32'hAA, 32'h0, 1);
      issue(3'd3, 32'd7, 32'd0, 1);               wait_idle();
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1); wait_idle();
      issue(3'd1, 32'd9, 32'd0, 1);               wait_idle();

      // A start while busy must be dropped, not queued
      issue(3'd0, 32'h00001234, 32'hFFFF0001, 1);
      repeat (5) @(negedge clk);
      op = 3'd3; src1 = 32'd50; src2 = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      // Cancel mid-multiply
      issue(3'd0, 32'd3, 32'd4, 0);
      repeat (8) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy", {31'b0, busy}, 32'd0);
      repeat (40) @(negedge clk);
      chk("cancel_hi", hi_data, m_hi);
      chk("cancel_lo", lo_data, m_lo);

      // Cancel beats a simultaneous MTHI
      op = 3'd4; src1 = 32'hDEADBEEF; start = 1'b1; cancel = 1'b1;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      chk("cancel_mthi", hi_data, m_hi);

      // Reset mid-divide
      issue(3'd3, 32'd100, 32'd7, 0);
      repeat (19) @(negedge clk);
      resten = 1'b1;
      @(negedge clk);
      resten = 1'b0;
      m_hi = '0; m_lo = '0;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_hi", hi_data, 32'd0);
      chk("midrst_lo", lo_data, 32'd0);
      issue(3'd0, 32'd2, 32'd3, 1); wait_idle();

      // Random ops, some back-to-back on the done cycle
      for (int i = 0; i < 40; i++) begin
         logic [2:0]      ro;
         logic [XLEN-1:0] ra, rb;
         ro = 3'($urandom_range(0, 7));
         ra = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom_range(0, 3);
            1:       rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         issue(ro, ra, rb, 1);
         wait_idle();
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
